// File: rtl/bram_pkg.sv
// Shared constants and request payload type for the BRAM port initiators.
package bram_pkg;

  localparam int unsigned BRAM_ABITS = 11;
  localparam int unsigned BRAM_DBITS = 8;
  localparam int unsigned RD_LATENCY = 1;

  typedef struct packed {
    logic                  write;
    logic [BRAM_ABITS-1:0] addr;
    logic [BRAM_DBITS-1:0] data;
  } bram_req_t;

endpackage

// File: rtl/bram_rsp_fifo.sv
// Small synchronous FIFO holding read data until the response consumer takes it.
module bram_rsp_fifo #(
  parameter int unsigned DBITS = 8,
  parameter int unsigned DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DBITS-1:0]             push_data,
  input  logic                         pop,
  output logic [DBITS-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DBITS-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop && (cnt != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign count    = cnt;

endmodule

// File: rtl/bram_port_master.sv
// Valid/ready initiator for one BRAM macro port with credit-managed read response FIFO.
module bram_port_master
  import bram_pkg::*;
#(
  parameter int unsigned ABITS     = BRAM_ABITS,
  parameter int unsigned DBITS     = BRAM_DBITS,
  parameter int unsigned RSP_DEPTH = 3
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [ABITS-1:0] req_addr,
  input  logic [DBITS-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DBITS-1:0] rsp_data,
  output logic [ABITS-1:0] mem_A,
  output logic [DBITS-1:0] mem_D,
  output logic             mem_WE,
  output logic             mem_CE,
  input  logic [DBITS-1:0] mem_Q
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  bram_req_t      req;
  logic           accept;
  logic           rd_pend;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic [OW-1:0]  occ;

  always_comb begin
    req       = '0;
    req.write = req_write;
    req.addr  = BRAM_ABITS'(req_addr);
    req.data  = BRAM_DBITS'(req_data);
  end

  // Credits cover both the read in flight and buffered data, so a push never overflows.
  assign occ       = OW'(fifo_count) + OW'(rd_pend);
  assign req_ready = RSTN && (occ < OW'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;

  assign mem_CE = accept;
  assign mem_WE = accept && req.write;
  assign mem_A  = RSTN ? ABITS'(req.addr) : '0;
  assign mem_D  = RSTN ? DBITS'(req.data) : '0;

  // Marks the cycle in which the macro presents Q for a read issued last cycle.
  always_ff @(posedge CLK) begin
    if (!RSTN) rd_pend <= 1'b0;
    else       rd_pend <= accept && !req.write;
  end

  bram_rsp_fifo #(
    .DBITS (DBITS),
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RSTN),
    .push      (rd_pend),
    .push_data (mem_Q),
    .pop       (rsp_valid && rsp_ready),
    .pop_data  (rsp_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid = RSTN && !fifo_empty;

  a_no_push_full: assert property (@(posedge CLK) disable iff (!RSTN) !(rd_pend && fifo_full));

endmodule

// File: tb/tb_bram_port_master.sv
// Directed bench for bram_port_master with a behavioural macro model and response log.
module tb_bram_port_master;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [10:0] req_addr;
  logic [7:0]  req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [10:0] mem_A;
  logic [7:0]  mem_D;
  logic        mem_WE;
  logic        mem_CE;
  logic [7:0]  mem_Q;

  bram_port_master #(.ABITS(11), .DBITS(8), .RSP_DEPTH(3)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_A(mem_A), .mem_D(mem_D), .mem_WE(mem_WE), .mem_CE(mem_CE), .mem_Q(mem_Q)
  );

  always #5 CLK = ~CLK;

  // Macro model: unwritten words read back as the low byte of their address.
  bit [7:0] mem [2048];
  bit       wr  [2048];
  int       we_count = 0;
  always @(posedge CLK) begin
    if (mem_CE) begin
      if (mem_WE) begin
        mem[mem_A] <= mem_D;
        wr[mem_A]  <= 1'b1;
        we_count   <= we_count + 1;
      end else begin
        mem_Q <= wr[mem_A] ? mem[mem_A] : mem_A[7:0];
      end
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Response log: every handshake, with the cycle it completed in.
  logic [7:0] got [$];
  int         got_cyc [$];
  always @(negedge CLK) begin
    if (rsp_valid && rsp_ready) begin
      got.push_back(rsp_data);
      got_cyc.push_back(cyc);
    end
  end

  int vectors = 0;
  int miscompares = 0;
  logic fire;
  int   fire_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: note whether the current request is accepted, then step past the edge.
  task automatic cycle();
    @(negedge CLK);
    fire = req_valid && req_ready;
    if (fire) fire_cyc = cyc;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input logic w, input logic [10:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
  endtask

  task automatic wait_rsp(input int n, input string tag);
    for (int k = 0; k < 40 && got.size() < n; k++) cycle();
    check(tag, got.size(), n);
  endtask

  int base;
  int t0;
  int idx;

  initial begin
    RSTN = 1'b0; rsp_ready = 1'b1;
    set_req(1'b1, 11'h005, 8'h33);

    // Reset held with a pending write request
    repeat (3) begin
      @(negedge CLK);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_mem_ce", mem_CE, 0);
      check("rst_mem_we", mem_WE, 0);
    end
    @(posedge CLK); #1;
    RSTN = 1'b1; req_valid = 1'b0;
    @(negedge CLK);
    check("rst_no_writes", we_count, 0);
    check("post_rst_ready", req_ready, 1);
    @(posedge CLK); #1;

    // Write then read back the top address
    base = got.size();
    set_req(1'b1, 11'h7FF, 8'hA5);
    cycle();
    check("wr_accept", fire, 1);
    set_req(1'b0, 11'h7FF, 8'h00);
    cycle();
    check("rd_accept", fire, 1);
    t0 = fire_cyc;
    req_valid = 1'b0;
    wait_rsp(base + 1, "wr_rd_count");
    if (got.size() > base) begin
      check("wr_rd_data", got[base], 8'hA5);
      check("wr_rd_latency", got_cyc[base] - t0, 2);
    end
    check("we_pulses", we_count, 1);

    // Streaming 16 reads with the consumer always ready
    base = got.size();
    for (int i = 0; i < 16; i++) begin
      set_req(1'b0, 11'(i), 8'h00);
      cycle();
      check("stream_ready", fire, 1);
      if (i == 0) t0 = fire_cyc;
    end
    req_valid = 1'b0;
    wait_rsp(base + 16, "stream_count");
    for (int i = 0; i < 16; i++) begin
      if (got.size() > base + i) begin
        check("stream_data", got[base+i], 32'(i));
        check("stream_cycle", got_cyc[base+i] - t0, 2 + i);
      end
    end

    // Backpressure: five reads offered, only three fit while the consumer stalls
    base = got.size();
    rsp_ready = 1'b0;
    idx = 0;
    set_req(1'b0, 11'd20, 8'h00);
    repeat (8) begin
      cycle();
      if (fire) begin
        idx++;
        if (idx < 5) req_addr = 11'(20 + idx);
        else         req_valid = 1'b0;
      end
    end
    check("bp_accepted", idx, 3);
    check("bp_ready_low", req_ready, 0);
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_rsp_held", rsp_data, 8'h14);
    rsp_ready = 1'b1;
    for (int k = 0; k < 20 && idx < 5; k++) begin
      cycle();
      if (fire) begin
        idx++;
        if (idx < 5) req_addr = 11'(20 + idx);
        else         req_valid = 1'b0;
      end
    end
    check("bp_all_accepted", idx, 5);
    req_valid = 1'b0;
    wait_rsp(base + 5, "bp_count");
    for (int i = 0; i < 5; i++)
      if (got.size() > base + i) check("bp_data", got[base+i], 32'(8'h14 + i));

    // Reset in the cycle after a read accept discards that read
    repeat (3) cycle();
    base = got.size();
    set_req(1'b0, 11'd3, 8'h00);
    cycle();
    check("mid_rst_accept", fire, 1);
    RSTN = 1'b0; req_valid = 1'b0;
    repeat (2) cycle();
    check("mid_rst_ready", req_ready, 0);
    RSTN = 1'b1;
    cycle();
    check("mid_rst_ready_back", req_ready, 1);
    check("mid_rst_empty", rsp_valid, 0);
    repeat (5) cycle();
    check("mid_rst_no_rsp", got.size(), base);

    // Push and pop in the same cycle with two entries buffered
    base = got.size();
    rsp_ready = 1'b0;
    idx = 0;
    set_req(1'b0, 11'd48, 8'h00);
    for (int k = 0; k < 10 && idx < 3; k++) begin
      cycle();
      if (fire) begin
        idx++;
        if (idx < 3) req_addr = 11'(48 + idx);
        else         req_valid = 1'b0;
      end
    end
    check("pp_accepted", idx, 3);
    check("pp_count_before", dut.u_fifo.count, 2);
    check("pp_pending", dut.rd_pend, 1);
    rsp_ready = 1'b1;
    cycle();
    check("pp_count_after", dut.u_fifo.count, 2);
    wait_rsp(base + 3, "pp_total");
    repeat (4) cycle();
    check("pp_no_dup", got.size(), base + 3);
    for (int i = 0; i < 3; i++)
      if (got.size() > base + i) check("pp_data", got[base+i], 32'(8'h30 + i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bram_port_master.md
Name: bram_port_master

Overview:
- Initiator for one port of the team's dual-port BRAM macros (BRAM_<words>x<bits> wrappers over generic_sram).
- Converts a valid/ready request stream (read or write) into the single-cycle A/D/WE/CE port strobes the macro expects.
- Captures Q one cycle after each read and returns read data on a valid/ready response stream through a small credit-managed FIFO, so the response consumer may backpressure freely.
- Sits between accelerator datapath logic and one BRAM port; two instances serve ports 0 and 1.

Parameters:
- ABITS, 11, address width; matches the macro depth (2048 words).
- DBITS, 8, data width.
- RSP_DEPTH, 3, response FIFO entries. Must be at least 2. A value of 3 or more is required for one read per cycle with rsp_ready held high.

Ports:
- CLK  in  1  clock; sole clock domain.
- RSTN  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ABITS  word address.
- req_data  in  DBITS  write data; ignored for reads.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes rsp_data.
- rsp_data  out  DBITS  read data, returned in request order.
- mem_A  out  ABITS  to macro A0/A1.
- mem_D  out  DBITS  to macro D0/D1.
- mem_WE  out  1  to macro WE0/WE1.
- mem_CE  out  1  to macro CE0/CE1.
- mem_Q  in  DBITS  from macro Q0/Q1; valid the cycle after a read strobe.

Behaviour:
- Reset (RSTN low at a CLK edge):
  - rd_pend = 0 and the FIFO is emptied.
  - Outputs while RSTN is low: rsp_valid = 0, req_ready = 0, mem_CE = 0, mem_WE = 0.
  - mem_A and mem_D are don't-care but driven to 0.
  - A read in flight at reset is discarded; its data is never returned.
- Credits:
  - occ = rd_pend + fifo_count.
  - req_ready = RSTN and (occ < RSP_DEPTH), registered-derived.
  - req_ready has no combinational path from rsp_ready or req_valid.
  - Writes are gated by the same credit rule, which keeps ordering simple.
- Issue, in the accept cycle N, combinational from the request:
  - mem_CE = accept.
  - mem_WE = accept and req_write.
  - mem_A = req_addr.
  - mem_D = req_data.
  - No port activity when there is no accept.
- Read pipeline:
  - rd_pend is set at the end of cycle N when a read is accepted, else cleared.
  - When rd_pend = 1 in cycle N+1, mem_Q is pushed into the FIFO at the end of N+1.
  - rsp_valid rises in N+2. Fixed read-to-response latency is 2 cycles.
- Writes:
  - Take effect at the macro at the end of cycle N.
  - Produce no response.
  - A read of the same address accepted in N+1 or later returns the new data.
- Response:
  - rsp_valid = FIFO not empty; rsp_data = FIFO head.
  - Pop when rsp_valid and rsp_ready.
  - rsp_data is held stable while rsp_valid is high and rsp_ready is low.
- Simultaneous push and pop: allowed in any occupancy state, count unchanged.
- Overflow is impossible by construction. An assertion must flag push while full.
- Pop while empty is ignored, since rsp_valid = 0.
- Address wrap: none. Addresses are used verbatim; no auto-increment.
- Throughput:
  - RSP_DEPTH = 3 with rsp_ready high: one read per cycle sustained.
  - With rsp_ready low: at most RSP_DEPTH reads issue, then req_ready drops.

Decomposition:
- Package bram_pkg:
  - Constants BRAM_ABITS = 11 and BRAM_DBITS = 8.
  - Request struct {write, addr, data}.
  - RD_LATENCY = 1, the macro latency constant.
- Sub-module bram_rsp_fifo: synchronous FIFO, parameters DBITS and DEPTH, with push, pop, full, empty and count outputs.
- The top module holds the credit logic, issue logic and rd_pend.

Test Plan:
- Reset: hold RSTN = 0 for 3 cycles with req_valid = 1 -> req_ready, rsp_valid, mem_CE and mem_WE all 0; no macro writes occur.
- Write 0xA5 to address 0x7FF, then read 0x7FF in the next cycle -> mem_WE pulses exactly one cycle; rsp_data = 0xA5 with rsp_valid high 2 cycles after the read accept.
- Streaming: back-to-back reads of addresses 0..15 (preloaded with data = addr) with rsp_ready = 1 -> req_ready stays 1; responses 0x00..0x0F arrive in order, one per cycle, starting at latency 2.
- Backpressure: rsp_ready = 0 while issuing 5 reads -> exactly 3 accepted, then req_ready = 0 and rsp_data held at the first value. Raise rsp_ready -> remaining reads accepted; all 5 are returned in order.
- Reset mid-operation: assert RSTN = 0 in the cycle after a read accept -> no response emerges after reset; the FIFO is empty and req_ready returns to 1 one cycle after RSTN is released.
- Simultaneous push and pop: FIFO at 2 entries with a read completing while rsp_ready = 1 -> count stays 2; no data is lost or duplicated (scoreboard check).
